// File: rtl/motor_sequencer.sv
// Two-wheel motor sequencer: decodes registered turn commands into per-wheel PWM
// enables and polarities, braking for a dead time before any polarity reversal.
module motor_sequencer #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FULL  = 1000,
  parameter int DUTY_VEER  = 700,
  parameter int DUTY_HARD  = 400,
  parameter int DEAD_TIME  = 50_000,
  parameter int NINETY_MAX = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir_cmd,
  input  logic       direction,
  output logic       l_en,
  output logic       r_en,
  output logic       l_fwd,
  output logic       r_fwd,
  output logic       busy,
  output logic       fault,
  output logic [1:0] dbg_state_o
);

  localparam int PW = 16;
  localparam int DW = $clog2(DEAD_TIME + 1);
  localparam int NW = $clog2(NINETY_MAX + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [PW-1:0] DUTY_FULL_W = PW'(DUTY_FULL);
  localparam logic [PW-1:0] DUTY_VEER_W = PW'(DUTY_VEER);
  localparam logic [PW-1:0] DUTY_HARD_W = PW'(DUTY_HARD);
  localparam logic [DW-1:0] DEAD_LAST   = DW'(DEAD_TIME - 1);
  localparam logic [NW-1:0] NINETY_LAST = NW'(NINETY_MAX - 1);

  localparam logic [3:0] CMD_PROCEED  = 4'b0000;
  localparam logic [3:0] CMD_VEER_R   = 4'b1001;
  localparam logic [3:0] CMD_HARD_R   = 4'b1010;
  localparam logic [3:0] CMD_NINETY_R = 4'b1011;
  localparam logic [3:0] CMD_VEER_L   = 4'b0101;
  localparam logic [3:0] CMD_HARD_L   = 4'b0110;
  localparam logic [3:0] CMD_NINETY_L = 4'b0111;
  localparam logic [3:0] CMD_STOP     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cmd_q;
  logic          dir_q;
  logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0] duty_l_q, duty_l_d;
  logic [PW-1:0] duty_r_q, duty_r_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [NW-1:0] ninety_cnt_q, ninety_cnt_d;
  logic          fault_q, fault_d;
  logic          l_en_q, l_en_d;
  logic          r_en_q, r_en_d;
  logic          l_fwd_q, l_fwd_d;
  logic          r_fwd_q, r_fwd_d;
  logic          busy_q, busy_d;

  // Decoded target for the registered command
  logic          is_ninety;
  logic          tgt_stop;
  logic          tgt_l_fwd, tgt_r_fwd;
  logic [PW-1:0] tgt_duty_l, tgt_duty_r;
  logic          pol_diff;
  logic          period_end;
  logic          ninety_trip;

  always_comb begin
    is_ninety  = (cmd_q == CMD_NINETY_R) || (cmd_q == CMD_NINETY_L);
    tgt_stop   = 1'b0;
    tgt_l_fwd  = 1'b1;
    tgt_r_fwd  = 1'b1;
    tgt_duty_l = DUTY_FULL_W;
    tgt_duty_r = DUTY_FULL_W;
    case (cmd_q)
      CMD_PROCEED:  begin end
      CMD_VEER_R:   tgt_duty_r = DUTY_VEER_W;
      CMD_HARD_R:   tgt_duty_r = DUTY_HARD_W;
      CMD_NINETY_R: tgt_r_fwd  = 1'b0;
      CMD_VEER_L:   tgt_duty_l = DUTY_VEER_W;
      CMD_HARD_L:   tgt_duty_l = DUTY_HARD_W;
      CMD_NINETY_L: tgt_l_fwd  = 1'b0;
      default:      tgt_stop   = 1'b1;
    endcase
    // While faulted, a lingering ninety code is read as STOP
    if (fault_q && is_ninety) begin
      tgt_stop  = 1'b1;
      tgt_l_fwd = 1'b1;
      tgt_r_fwd = 1'b1;
    end
    if (tgt_stop) begin
      tgt_duty_l = '0;
      tgt_duty_r = '0;
    end
    // Reversing travel flips both wheels; sides are never swapped
    if (!dir_q) begin
      tgt_l_fwd = ~tgt_l_fwd;
      tgt_r_fwd = ~tgt_r_fwd;
    end
  end

  always_comb begin
    state_d      = state_q;
    dead_cnt_d   = dead_cnt_q;
    ninety_cnt_d = '0;
    fault_d      = fault_q;
    ninety_trip  = 1'b0;
    l_fwd_d      = l_fwd_q;
    r_fwd_d      = r_fwd_q;

    period_end = (pwm_cnt_q == PERIOD_LAST);
    pwm_cnt_d  = period_end ? '0 : pwm_cnt_q + PW'(1);
    duty_l_d   = period_end ? tgt_duty_l : duty_l_q;
    duty_r_d   = period_end ? tgt_duty_r : duty_r_q;
    pol_diff   = (tgt_l_fwd != l_fwd_q) || (tgt_r_fwd != r_fwd_q);

    if (fault_q && !is_ninety) begin
      fault_d = 1'b0;
    end

    if ((state_q != ST_IDLE) && is_ninety && !fault_q) begin
      if (ninety_cnt_q == NINETY_LAST) begin
        ninety_trip = 1'b1;
      end else begin
        ninety_cnt_d = ninety_cnt_q + NW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!tgt_stop) begin
          if (pol_diff) begin
            state_d    = ST_BRAKE;
            dead_cnt_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // STOP wins over a polarity change
        if (tgt_stop) begin
          state_d = ST_IDLE;
        end else if (pol_diff) begin
          state_d    = ST_BRAKE;
          dead_cnt_d = '0;
        end
      end
      ST_BRAKE: begin
        if (dead_cnt_q == DEAD_LAST) begin
          l_fwd_d = tgt_l_fwd;
          r_fwd_d = tgt_r_fwd;
          state_d = tgt_stop ? ST_IDLE : ST_RUN;
        end else begin
          dead_cnt_d = dead_cnt_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ninety_trip) begin
      state_d = ST_IDLE;
      fault_d = 1'b1;
    end

    l_en_d = (state_d == ST_RUN) && (pwm_cnt_d < duty_l_d);
    r_en_d = (state_d == ST_RUN) && (pwm_cnt_d < duty_r_d);
    busy_d = (state_d == ST_BRAKE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_STOP;
      dir_q        <= 1'b0;
      pwm_cnt_q    <= '0;
      duty_l_q     <= '0;
      duty_r_q     <= '0;
      dead_cnt_q   <= '0;
      ninety_cnt_q <= '0;
      fault_q      <= 1'b0;
      l_en_q       <= 1'b0;
      r_en_q       <= 1'b0;
      l_fwd_q      <= 1'b1;
      r_fwd_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= dir_cmd;
      dir_q        <= direction;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_l_q     <= duty_l_d;
      duty_r_q     <= duty_r_d;
      dead_cnt_q   <= dead_cnt_d;
      ninety_cnt_q <= ninety_cnt_d;
      fault_q      <= fault_d;
      l_en_q       <= l_en_d;
      r_en_q       <= r_en_d;
      l_fwd_q      <= l_fwd_d;
      r_fwd_q      <= r_fwd_d;
      busy_q       <= busy_d;
    end
  end

  assign l_en        = l_en_q;
  assign r_en        = r_en_q;
  assign l_fwd       = l_fwd_q;
  assign r_fwd       = r_fwd_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign dbg_state_o = state_q;

endmodule
